// File: rtl/fifo_sync_param.sv
// Purpose: parametrised single-clock circular-buffer FIFO with occupancy count, thresholds and error pulses.
// Latency: a word written on cycle N is readable on N+1; registered mode returns data the cycle after get.
// Backpressure: a put at full is dropped unless a get frees a slot that cycle; a get at empty is ignored; both pulse an error flag.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AFULL_THR  = DEPTH - 2,
    parameter int AEMPTY_THR = 2,
    parameter int FWFT       = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         put,
    input  logic                         get,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             put_ok, get_ok;

    // Flags are decoded from the registered count only, so they never depend on this cycle's requests.
    assign full         = (count_q == CNT_W'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CNT_W'(AFULL_THR));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_THR));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A get at full frees a slot in the same cycle, so put may be accepted alongside it.
    assign get_ok = get & ~empty;
    assign put_ok = put & (~full | get_ok);

    // Next-state for pointers, occupancy and the one-cycle error pulses.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q + CNT_W'(put_ok) - CNT_W'(get_ok);
        overflow_d  = put & ~put_ok;
        underflow_d = get & ~get_ok;
        if (put_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (get_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    // Control state; reset discards all stored words at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (put_ok) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented continuously; forced to zero when empty so the bus is quiet.
            assign data_out = empty ? '0 : mem[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;
            // Output register loads the head word only on an accepted get and holds otherwise.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (get_ok) begin
                    dout_q <= mem[rd_ptr_q];
                end
            end
            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_sync_param.sv
module tb_fifo_sync_param;

    localparam int DW    = 32;
    localparam int DEPTH = 16;
    localparam int AFULL = DEPTH - 2;
    localparam int AEMPT = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] data_in;
    logic          put, get;

    logic [DW-1:0] data_out0, data_out1;
    logic          full0, empty0, af0, ae0, ovf0, unf0;
    logic          full1, empty1, af1, ae1, ovf1, unf1;
    logic [4:0]    count0, count1;

    int total = 0;
    int bad   = 0;

    // Reference model: a plain queue of stored words plus the expected registered outputs.
    logic [DW-1:0] q[$];
    logic [DW-1:0] exp_dout;
    logic          exp_ovf, exp_unf;

    always #5 clk = ~clk;

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THR(AFULL), .AEMPTY_THR(AEMPT), .FWFT(0)) dut0 (
        .clk(clk), .rst(rst), .data_in(data_in), .put(put), .get(get),
        .data_out(data_out0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(unf0)
    );

    fifo_sync_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THR(AFULL), .AEMPTY_THR(AEMPT), .FWFT(1)) dut1 (
        .clk(clk), .rst(rst), .data_in(data_in), .put(put), .get(get),
        .data_out(data_out1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(unf1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int n;
        n = q.size();
        chk("count0", 64'(count0), 64'(n));
        chk("full0", 64'(full0), 64'(n == DEPTH));
        chk("empty0", 64'(empty0), 64'(n == 0));
        chk("afull0", 64'(af0), 64'(n >= AFULL));
        chk("aempty0", 64'(ae0), 64'(n <= AEMPT));
        chk("ovf0", 64'(ovf0), 64'(exp_ovf));
        chk("unf0", 64'(unf0), 64'(exp_unf));
        chk("dout0", 64'(data_out0), 64'(exp_dout));
        chk("count1", 64'(count1), 64'(n));
        chk("ovf1", 64'(ovf1), 64'(exp_ovf));
        chk("unf1", 64'(unf1), 64'(exp_unf));
        if (n != 0) begin
            chk("dout1_fwft", 64'(data_out1), 64'(q[0]));
        end
    endtask

    // One clock cycle: drive on the falling edge, advance the model at the rising edge, check just after.
    task automatic step(input logic p, input logic g, input logic [DW-1:0] d);
        logic gok, pok;
        @(negedge clk);
        put = p;
        get = g;
        data_in = d;
        @(posedge clk);
        gok = g && (q.size() > 0);
        pok = p && ((q.size() < DEPTH) || gok);
        exp_ovf = p && !pok;
        exp_unf = g && !gok;
        if (gok) exp_dout = q.pop_front();
        if (pok) q.push_back(d);
        #1;
        check_all();
    endtask

    initial begin
        logic p, g;
        rst = 1'b1;
        put = 1'b0;
        get = 1'b0;
        data_in = '0;
        exp_dout = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        #2;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Fill to full, then an overflowing put that must not be stored.
        for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, DW'(i));
        step(1'b1, 1'b0, 32'hAA);
        step(1'b0, 1'b0, 32'h0);
        // Put and get together at full: both accepted, no overflow.
        step(1'b1, 1'b1, 32'h55);
        // Drain everything, then one get too many.
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        // Put and get together at empty: only the put lands.
        step(1'b1, 1'b1, 32'h77);
        step(1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 32'h0);

        // Interleaved traffic holding occupancy around 3..5 across several pointer wraps.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, $urandom);
        for (int i = 0; i < 60; i++) begin
            p = (q.size() < 4) ? 1'b1 : ($urandom_range(0, 1) == 1);
            g = (q.size() > 4) ? 1'b1 : ($urandom_range(0, 1) == 1);
            step(p, g, $urandom);
        end

        // Unconstrained random traffic, biased so both full and empty are visited.
        for (int i = 0; i < 400; i++) begin
            if ((i / 50) % 2 == 0) begin
                p = ($urandom_range(0, 3) != 0);
                g = ($urandom_range(0, 3) == 0);
            end else begin
                p = ($urandom_range(0, 3) == 0);
                g = ($urandom_range(0, 3) != 0);
            end
            step(p, g, $urandom);
        end

        // Drain, then build occupancy 9 and hit reset between clock edges.
        while (q.size() > 0) step(1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, $urandom);
        chk("count_before_rst", 64'(count0), 64'd9);
        @(negedge clk);
        put = 1'b0;
        get = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        q.delete();
        exp_dout = '0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b0, 32'h3C);
        step(1'b0, 1'b1, 32'h0);
        chk("post_rst_read", 64'(data_out0), 64'h3C);
        step(1'b0, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
